// File: rtl/cnn_pool_3x3_stream.sv
// 3x3 average/max pooling over raster-ordered channel planes.
// Same-padding, stride 1/2, internal line buffers and end-of-plane flush.
module cnn_pool_3x3_stream #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 512,
    parameter int PIPE         = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  stride2,
    input  logic                  valid_in,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  plane_done,
    output logic                  frame_done
);

    localparam int DW   = DATA_WIDTH;
    localparam int W    = IMAGE_WIDTH;
    localparam int H    = IMAGE_HEIGHT;
    localparam int NPIX = W * H;
    localparam int S    = NPIX + W + 1;
    localparam int PB   = $clog2(S + 1);
    localparam int CB   = $clog2(W);
    localparam int RB   = $clog2(H);
    localparam int CHB  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int SW   = DW + 4;
    localparam int MW   = SW + 16;
    localparam int RL2  = (H - 1) - ((H - 1) % 2);
    localparam int CL2  = (W - 1) - ((W - 1) % 2);

    localparam logic [PB-1:0]  P_PIX_LAST = PB'(NPIX - 1);
    localparam logic [PB-1:0]  P_LAST     = PB'(S - 1);
    localparam logic [PB-1:0]  P_CEN      = PB'(W + 1);
    localparam logic [CB-1:0]  C_MAX      = CB'(W - 1);
    localparam logic [CB-1:0]  C_LAST2    = CB'(CL2);
    localparam logic [RB-1:0]  R_MAX      = RB'(H - 1);
    localparam logic [RB-1:0]  R_LAST2    = RB'(RL2);
    localparam logic [CHB-1:0] CH_MAX     = CHB'(CHANNEL_NUM - 1);

    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [MW-1:0] SMIN = MW'(MINV);
    localparam logic signed [MW-1:0] SMAX = MW'(MAXV);
    localparam logic signed [MW-1:0] K9   = MW'(7282);
    localparam logic signed [MW-1:0] RND  = MW'(32768);

    typedef enum logic {FILL, FLUSH} state_t;

    typedef struct packed {
        logic v;
        logic pd;
        logic fd;
        logic m;
    } tag_t;

    state_t state_q, state_d;

    logic [PB-1:0]  p_q;
    logic [CB-1:0]  pc_q;
    logic [RB-1:0]  cr_q;
    logic [CB-1:0]  cc_q;
    logic [CHB-1:0] ch_q;
    logic           mode_q, str_q;

    logic signed [DW-1:0] lb1 [W];
    logic signed [DW-1:0] lb2 [W];
    logic signed [DW-1:0] win [3][3];
    logic [RB-1:0]        s1_r;
    logic [CB-1:0]        s1_c;
    tag_t                 tag_q [PIPE];
    logic signed [SW-1:0] s2_val;
    logic [DW-1:0]        out_q;

    logic                 slot, accept, cen_on, plane_end, emit, last_c;
    logic signed [DW-1:0] x;

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == FILL);
        accept    = valid_in & in_ready;
        slot      = in_ready ? valid_in : 1'b1;
        plane_end = (state_q == FLUSH) && (p_q == P_LAST);
        cen_on    = (p_q >= P_CEN);
        x         = in_ready ? signed'(pxl_in) : '0;
        emit      = slot && cen_on && (!str_q || (!cr_q[0] && !cc_q[0]));
        last_c    = str_q ? (cr_q == R_LAST2 && cc_q == C_LAST2)
                          : (cr_q == R_MAX && cc_q == C_MAX);
        unique case (state_q)
            FILL:  if (accept && p_q == P_PIX_LAST) state_d = FLUSH;
            FLUSH: if (plane_end) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q    <= '0;
            pc_q   <= '0;
            cr_q   <= '0;
            cc_q   <= '0;
            ch_q   <= '0;
            mode_q <= 1'b0;
            str_q  <= 1'b0;
        end else begin
            // config only changes at the very start of a frame
            if (accept && p_q == '0 && ch_q == '0) begin
                mode_q <= mode;
                str_q  <= stride2;
            end
            if (slot) begin
                if (plane_end) begin
                    p_q  <= '0;
                    pc_q <= '0;
                    cr_q <= '0;
                    cc_q <= '0;
                    ch_q <= (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
                end else begin
                    p_q  <= p_q + 1'b1;
                    pc_q <= (pc_q == C_MAX) ? '0 : pc_q + 1'b1;
                    if (cen_on) begin
                        if (cc_q == C_MAX) begin
                            cc_q <= '0;
                            cr_q <= cr_q + 1'b1;
                        end else begin
                            cc_q <= cc_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < W; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
            s1_r <= '0;
            s1_c <= '0;
        end else if (slot) begin
            lb2[pc_q] <= lb1[pc_q];
            lb1[pc_q] <= x;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2[pc_q];
            win[1][2] <= lb1[pc_q];
            win[2][2] <= x;
            s1_r      <= cr_q;
            s1_c      <= cc_q;
        end
    end

    logic signed [SW-1:0] sum;
    logic signed [DW-1:0] mx, tap;
    logic                 pad;

    // wrapped columns and stale rows are always masked by the centre position
    always_comb begin
        sum = '0;
        mx  = MINV;
        tap = '0;
        pad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pad = (i == 0 && s1_r == '0) || (i == 2 && s1_r == R_MAX) ||
                      (j == 0 && s1_c == '0) || (j == 2 && s1_c == C_MAX);
                tap = pad ? (tag_q[0].m ? MINV : '0) : win[i][j];
                sum = sum + SW'(tap);
                if (tap > mx) mx = tap;
            end
        end
    end

    logic signed [MW-1:0] prod, q;
    logic [DW-1:0]        avg;

    always_comb begin
        prod = MW'(s2_val) * K9 + RND;
        q    = prod >>> 16;
        if (q > SMAX)      avg = MAXV;
        else if (q < SMIN) avg = MINV;
        else               avg = q[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) tag_q[i] <= '0;
            s2_val <= '0;
            out_q  <= '0;
        end else begin
            tag_q[0] <= slot ? '{v:  emit,
                                 pd: emit & last_c,
                                 fd: emit & last_c & (ch_q == CH_MAX),
                                 m:  mode_q} : '0;
            for (int i = 1; i < PIPE; i++) tag_q[i] <= tag_q[i-1];
            s2_val <= tag_q[0].m ? SW'(mx) : sum;
            if (tag_q[1].v) out_q <= tag_q[1].m ? s2_val[DW-1:0] : avg;
        end
    end

    assign pxl_out    = out_q;
    assign valid_out  = tag_q[PIPE-1].v;
    assign plane_done = tag_q[PIPE-1].pd;
    assign frame_done = tag_q[PIPE-1].fd;

endmodule

// File: tb/tb_cnn_pool_3x3_stream.sv
// Bench for cnn_pool_3x3_stream: table vectors, ramp, random frames
// against a direct 3x3 window model, plus a mid-frame reset sequence.
module tb_cnn_pool_3x3_stream;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int DW   = 16;
    localparam int CH   = 2;
    localparam int PIPE = 3;
    localparam int S    = W * H + W + 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 mode = 1'b0;
    logic                 stride2 = 1'b0;
    logic                 valid_in = 1'b0;
    logic signed [DW-1:0] pxl_in = '0;
    logic signed [DW-1:0] pxl_out;
    logic                 in_ready, valid_out, plane_done, frame_done;

    always #5 clk = ~clk;

    cnn_pool_3x3_stream #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
        .CHANNEL_NUM(CH), .PIPE(PIPE)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .stride2(stride2),
        .valid_in(valid_in), .in_ready(in_ready), .pxl_in(pxl_in),
        .pxl_out(pxl_out), .valid_out(valid_out),
        .plane_done(plane_done), .frame_done(frame_done)
    );

    typedef struct {
        logic signed [DW-1:0] v;
        bit pd;
        bit fd;
    } exp_t;

    typedef struct {
        bit mode;
        bit str;
        int fill;
        bit gaps;
        int e_cor;
        int e_edge;
        int e_int;
    } vec_t;

    exp_t   exp_q[$];
    longint t_q[$];
    int     checks = 0, errors = 0;
    int     cyc = 0, slot_idx = 0, low_run = 0, fd_count = 0;
    bit     cur_str = 0, gaps_on = 0;
    int     img[CH][H][W];

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, req);
        end
    endfunction

    function automatic bit emitted(bit str, int r, int c);
        return !str || (r % 2 == 0 && c % 2 == 0);
    endfunction

    function automatic bit is_last(bit str, int r, int c);
        int lr, lc;
        lr = str ? (H - 1) - ((H - 1) % 2) : H - 1;
        lc = str ? (W - 1) - ((W - 1) % 2) : W - 1;
        return r == lr && c == lc;
    endfunction

    function automatic int ref_px(int ch, int r, int c, bit m);
        longint sum = 0, a;
        int mx = -32768, v, rr, cc;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) v = img[ch][rr][cc];
                else v = m ? -32768 : 0;
                sum += v;
                if (v > mx) mx = v;
            end
        if (m) return mx;
        a = (sum * 7282 + 32768) >>> 16;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        return int'(a);
    endfunction

    task automatic push(int v, bit str, int ch, int r, int c);
        exp_t e;
        e.v  = DW'(v);
        e.pd = is_last(str, r, c);
        e.fd = is_last(str, r, c) && ch == CH - 1;
        exp_q.push_back(e);
    endtask

    task automatic push_model(bit m, bit s);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    if (emitted(s, r, c)) push(ref_px(ch, r, c, m), s, ch, r, c);
    endtask

    task automatic push_table(vec_t t);
        int nb, v;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    if (emitted(t.str, r, c)) begin
                        nb = int'(r == 0 || r == H - 1) + int'(c == 0 || c == W - 1);
                        v  = (nb == 2) ? t.e_cor : (nb == 1) ? t.e_edge : t.e_int;
                        push(v, t.str, ch, r, c);
                    end
    endtask

    task automatic put(int v);
        int n = 0;
        if (gaps_on)
            while ($urandom_range(1, 0) == 1) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
        valid_in = 1'b1;
        pxl_in   = DW'(v);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drive_frame(bit m, bit s, bit toggle);
        cur_str = s;
        mode    = m;
        stride2 = s;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    put(img[ch][r][c]);
                    if (toggle && ch == 0 && r == 0 && c == 0) begin
                        mode    = ~m;
                        stride2 = ~s;
                    end
                end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || t_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0 || t_q.size() != 0) begin
            chk("drain_pending", exp_q.size() + t_q.size(), 0);
            exp_q.delete();
            t_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   k, r, c;
        cyc++;
        if (reset) begin
            slot_idx = 0;
            low_run  = 0;
            chk("valid_out_in_reset", valid_out, 0);
        end else begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", valid_out, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pxl_out", pxl_out, e.v);
                    chk("plane_done", plane_done, e.pd);
                    chk("frame_done", frame_done, e.fd);
                    if (t_q.size() != 0) chk("latency", cyc, t_q.pop_front());
                    else chk("latency_no_slot", valid_out, 0);
                end
                if (frame_done) fd_count++;
            end else if (plane_done || frame_done) begin
                chk("done_without_valid", plane_done | frame_done, 0);
            end
            if (!in_ready) low_run++;
            else if (low_run != 0) begin
                chk("flush_len", low_run, W + 1);
                low_run = 0;
            end
            if ((valid_in && in_ready) || !in_ready) begin
                if (slot_idx >= W + 1) begin
                    k = slot_idx - W - 1;
                    r = k / W;
                    c = k % W;
                    if (emitted(cur_str, r, c)) t_q.push_back(cyc + PIPE);
                end
                slot_idx = (slot_idx == S - 1) ? 0 : slot_idx + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        bit   rm, rs;
        tbl[0] = '{0, 0, 9,      0, 4,      6,      9};
        tbl[1] = '{0, 1, 9,      0, 4,      6,      9};
        tbl[2] = '{0, 0, 32767,  0, 14564,  21845,  32767};
        tbl[3] = '{0, 0, -32768, 0, -14564, -21846, -32768};
        tbl[4] = '{1, 0, -7,     0, -7,     -7,     -7};
        tbl[5] = '{1, 1, 1000,   0, 1000,   1000,   1000};
        tbl[6] = '{0, 0, 9,      1, 4,      6,      9};
        tbl[7] = '{1, 0, -32768, 1, -32768, -32768, -32768};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_pxl_out", pxl_out, 0);
        chk("reset_plane_done", plane_done, 0);
        chk("reset_frame_done", frame_done, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            for (int ch = 0; ch < CH; ch++)
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        img[ch][r][c] = tbl[i].fill;
            gaps_on = tbl[i].gaps;
            push_table(tbl[i]);
            drive_frame(tbl[i].mode, tbl[i].str, 1'b0);
            drain();
        end

        gaps_on = 0;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    img[ch][r][c] = r * W + c;
                    push((r + 1 < H - 1 ? r + 1 : H - 1) * W +
                         (c + 1 < W - 1 ? c + 1 : W - 1), 1'b0, ch, r, c);
                end
        drive_frame(1'b1, 1'b0, 1'b0);
        drain();

        for (int f = 0; f < 6; f++) begin
            rm = f[0];
            rs = f[1];
            gaps_on = $urandom_range(1, 0) == 1;
            for (int ch = 0; ch < CH; ch++)
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        img[ch][r][c] = (f == 5) ? 32767 - int'($urandom_range(3, 0))
                                                 : int'($urandom_range(65535, 0)) - 32768;
            push_model(rm, rs);
            drive_frame(rm, rs, 1'b1);
            drain();
        end

        gaps_on = 0;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[ch][r][c] = 9;
        cur_str = 0;
        mode    = 0;
        stride2 = 0;
        push_model(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) put(9);
        reset = 1'b1;
        exp_q.delete();
        t_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reset_in_ready", in_ready, 1);
        chk("mid_reset_pxl_out", pxl_out, 0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        fd_count = 0;
        push_model(1'b0, 1'b0);
        drive_frame(1'b0, 1'b0, 1'b0);
        drain();
        chk("frame_done_count", fd_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
